speaker_control: RTL and testbench

- Serializes the stereo 16-bit audio sample pair produced by the buzzer/note generator into an I2S stream for the on-board audio DAC.
- Generates the DAC clocks (MCLK, LRCK, SCK) from the system clock.
- Latches one left/right sample pair per frame and shifts each word out MSB-first in I2S format.
- Sits between the note generator's audio_left/audio_right outputs and the DAC pins.

---
 rtl/speaker_control.sv | 59 +++++
 tb/tb_speaker_control.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/speaker_control.sv
// I2S serializer for the on-board audio DAC. It derives MCLK, SCK and LRCK from one
// free-running frame counter and shifts out one latched stereo sample pair per frame.
module speaker_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] audio_left,
    input  logic [15:0] audio_right,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin,
    output logic        sample_tick
);

    logic [9:0]  cnt;
    logic [9:0]  cnt_next;
    logic        wrap;
    logic [15:0] hold_l;
    logic [15:0] hold_r;
    logic [15:0] hold_c;
    logic [4:0]  slot_next;
    logic        sdin_next;

    // sdin is registered, so it is computed from the count value it will
    // accompany. That value only reaches data slots after the hold registers
    // have taken the new pair.
    always_comb begin
        cnt_next  = cnt + 10'd1;
        wrap      = (cnt == 10'h3FF);
        slot_next = cnt_next[8:4];
        hold_c    = cnt_next[9] ? hold_r : hold_l;
        sdin_next = 1'b0;
        if (slot_next >= 5'd1 && slot_next <= 5'd16)
            sdin_next = hold_c[4'(5'd16 - slot_next)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            hold_l      <= '0;
            hold_r      <= '0;
            audio_sdin  <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            sample_tick <= wrap;
            audio_sdin  <= sdin_next;
            if (wrap) begin
                hold_l <= audio_left;
                hold_r <= audio_right;
            end
        end
    end

    assign audio_mclk = cnt[1];
    assign audio_sck  = cnt[3];
    assign audio_lrck = cnt[9];

endmodule

// File: tb/tb_speaker_control.sv
// Bench for speaker_control: a frame-level model checks every cycle, and an I2S
// decoder clocked by the DAC's SCK checks words against literal sample values.
module tb_speaker_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] audio_left  = '0;
    logic [15:0] audio_right = '0;
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;
    logic        sample_tick;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    speaker_control dut (
        .clk         (clk),
        .rst         (rst),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .audio_mclk  (audio_mclk),
        .audio_lrck  (audio_lrck),
        .audio_sck   (audio_sck),
        .audio_sdin  (audio_sdin),
        .sample_tick (sample_tick)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: t counts clk edges since reset release; a pair is captured when t
    // crosses a multiple of 1024.
    int          t;
    logic [15:0] ml;
    logic [15:0] mr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t  <= 0;
            ml <= '0;
            mr <= '0;
        end else begin
            if (t % 1024 == 1023) begin
                ml <= audio_left;
                mr <= audio_right;
            end
            t <= t + 1;
        end
    end

    // Returns {mclk, lrck, sck, sdin, tick}.
    function automatic logic [4:0] expect_out(input int tt, input logic [15:0] l,
                                              input logic [15:0] r, input logic in_rst);
        int          ph;
        int          s;
        logic [15:0] w;
        logic        sd;
        ph = tt % 1024;
        s  = (ph % 512) / 16;
        w  = (ph >= 512) ? r : l;
        sd = (s >= 1 && s <= 16) ? w[16 - s] : 1'b0;
        if (in_rst)
            return 5'b0;
        return {1'((ph / 2) % 2), 1'(ph >= 512), 1'((ph / 8) % 2), sd,
                1'(ph == 0 && tt >= 1024)};
    endfunction

    always @(negedge clk)
        check("outputs", {audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick},
              expect_out(t, ml, mr, rst));

    // Decoder: the slot count restarts on every LRCK change seen at an SCK rise.
    int          d_slot;
    int          d_next;
    logic        d_prev;
    logic [15:0] d_word;
    logic        d_pad_err;
    logic [15:0] dec_l;
    logic [15:0] dec_r;
    logic        pad_ok_l;
    logic        pad_ok_r;

    assign d_next = (audio_lrck != d_prev) ? 0 : d_slot + 1;

    always @(posedge audio_sck or posedge rst) begin
        if (rst) begin
            d_slot    <= -1;
            d_prev    <= 1'b0;
            d_word    <= '0;
            d_pad_err <= 1'b0;
            dec_l     <= 16'hDEAD;
            dec_r     <= 16'hDEAD;
            pad_ok_l  <= 1'b0;
            pad_ok_r  <= 1'b0;
        end else begin
            d_prev <= audio_lrck;
            d_slot <= d_next;
            if (d_next >= 1 && d_next <= 16)
                d_word <= {d_word[14:0], audio_sdin};
            else if (audio_sdin)
                d_pad_err <= 1'b1;
            if (d_next == 31) begin
                if (audio_lrck) begin
                    dec_r    <= d_word;
                    pad_ok_r <= !(d_pad_err || audio_sdin);
                end else begin
                    dec_l    <= d_word;
                    pad_ok_l <= !(d_pad_err || audio_sdin);
                end
                d_pad_err <= 1'b0;
            end
        end
    end

    task automatic wait_phase(input int p);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (t % 1024 != p && n < 2100);
        check("reach_phase", t % 1024, p);
    endtask

    task automatic check_left(input string name, input logic [15:0] exp);
        wait_phase(510);
        check(name, dec_l, exp);
        check({name, "_pad"}, pad_ok_l, 1);
    endtask

    task automatic check_right(input string name, input logic [15:0] exp);
        wait_phase(1020);
        check(name, dec_r, exp);
        check({name, "_pad"}, pad_ok_r, 1);
    endtask

    initial begin
        int fm = -1;
        int fs = -1;
        int fl = -1;
        int ft = -1;
        int st = -1;
        int ticks = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_tick}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Edge positions after release; the first two frames carry zeros.
        for (int n = 1; n <= 2048; n++) begin
            @(posedge clk);
            #1;
            if (audio_mclk && fm < 0) fm = n;
            if (audio_sck && fs < 0)  fs = n;
            if (audio_lrck && fl < 0) fl = n;
            if (sample_tick) begin
                ticks++;
                if (ft < 0) ft = n;
                else if (st < 0) st = n;
            end
        end
        check("first_mclk_rise", fm, 2);
        check("first_sck_rise", fs, 8);
        check("first_lrck_rise", fl, 512);
        check("first_tick", ft, 1024);
        check("second_tick", st, 2048);
        check("tick_count", ticks, 2);

        audio_left  = 16'hA5F0;
        audio_right = 16'h0F0F;
        wait_phase(0);
        check_left("serial_left", 16'hA5F0);
        check_right("serial_right", 16'h0F0F);

        audio_left = 16'h1234;
        wait_phase(0);
        wait_phase(300);
        audio_left = 16'hFFFF;
        check_left("midframe_old", 16'h1234);
        wait_phase(0);
        check_left("midframe_new", 16'hFFFF);

        audio_left  = 16'h8000;
        audio_right = 16'hFFFF;
        wait_phase(0);
        check_left("extreme_left", 16'h8000);
        check_right("extreme_right", 16'hFFFF);

        wait_phase(600);
        check("lrck_before_reset", audio_lrck, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_sdin", audio_sdin, 0);
        check("async_lrck", audio_lrck, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_left("post_reset_left0", 16'h0000);
        check_right("post_reset_right0", 16'h0000);
        check_left("post_reset_left1", 16'h8000);
        check_right("post_reset_right1", 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
